// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, access sizes and datapath width for the memory stage
package pipe_pkg;
  localparam int REG_SZ = 32;
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;
  typedef enum logic [1:0] {IDLE, MEM, SEND, DRAIN} state_t;
endpackage

// File: rtl/pipe_mem_ext.sv
// mem_ext: load extender; data/len/uns in, ext = byte/half/word zero- or sign-extended to REG_SZ
module mem_ext #(parameter int REG_SZ = pipe_pkg::REG_SZ) (
  input  logic [REG_SZ-1:0] data,
  input  logic [1:0]        len,
  input  logic              uns,
  output logic [REG_SZ-1:0] ext
);
  import pipe_pkg::*;
  logic sb, sh;
  always_comb begin
    sb = ~uns & data[7];
    sh = ~uns & data[15];
    ext = len == LEN_B ? {{(REG_SZ-8){sb}}, data[7:0]} :
          len == LEN_H ? {{(REG_SZ-16){sh}}, data[15:0]} : data;
  end
endmodule

// File: rtl/pipe_mem.sv
// pipe_mem: memory-access stage; up_syn/up_ack bundle in, mem_* single-access port, down_syn/down_ack write-back bundle out
module pipe_mem #(parameter int REG_SZ = pipe_pkg::REG_SZ) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_syn,
  output logic              up_ack,
  input  logic [4:0]        rd,
  input  logic [REG_SZ-1:0] ans,
  input  logic [REG_SZ-1:0] dout,
  input  logic              re,
  input  logic              we,
  input  logic [1:0]        rlen,
  input  logic [1:0]        wlen,
  input  logic              ld_uns,
  input  logic              wb_e,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_len,
  output logic [REG_SZ-1:0] mem_addr,
  output logic [REG_SZ-1:0] mem_wdata,
  input  logic [REG_SZ-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              down_syn,
  input  logic              down_ack,
  output logic [4:0]        wb_rd,
  output logic [REG_SZ-1:0] wb_data,
  output logic              wb_en
);
  import pipe_pkg::*;
  state_t state, state_n;
  logic cap, uns;
  logic [REG_SZ-1:0] ext;
  assign cap = state == IDLE && up_syn && !up_ack;
  mem_ext #(.REG_SZ(REG_SZ)) u_ext (.data(mem_rdata), .len(mem_len), .uns(uns), .ext(ext));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cap ? ((re | we) ? MEM : SEND) : IDLE;
      MEM:     state_n = mem_done ? SEND : MEM;
      SEND:    state_n = down_ack ? DRAIN : SEND;
      default: state_n = down_ack ? DRAIN : IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      up_ack <= 1'b0;
      down_syn <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_len <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_en <= 1'b0;
      uns <= 1'b0;
    end else begin
      if (!up_syn) up_ack <= 1'b0;
      else if (cap) up_ack <= 1'b1;
      if (cap) begin
        wb_rd <= rd;
        wb_en <= wb_e;
        mem_addr <= ans;
        mem_wdata <= dout;
        mem_we <= we & ~re;
        mem_len <= re ? rlen : wlen;
        uns <= ld_uns;
        if (re | we) mem_req <= 1'b1;
        else begin
          wb_data <= ans;
          down_syn <= 1'b1;
        end
      end
      if (state == MEM && mem_done) begin
        mem_req <= 1'b0;
        wb_data <= mem_we ? mem_addr : ext;
        if (mem_we) wb_en <= 1'b0;
        down_syn <= 1'b1;
      end
      if (state == SEND && down_ack) down_syn <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_mem.sv
// tb_pipe_mem: directed scoreboard bench with memory and write-back responders
module tb_pipe_mem;
  logic clk = 0, rst = 1;
  logic up_syn, up_ack, re, we, ld_uns, wb_e, mem_req, mem_we, mem_done, down_syn, down_ack, wb_en;
  logic [4:0] rd, wb_rd;
  logic [1:0] rlen, wlen, mem_len;
  logic [31:0] ans, dout, mem_addr, mem_wdata, mem_rdata, wb_data;
  always #5 clk = ~clk;
  pipe_mem #(.REG_SZ(32)) dut (
    .clk(clk), .rst(rst), .up_syn(up_syn), .up_ack(up_ack), .rd(rd), .ans(ans), .dout(dout),
    .re(re), .we(we), .rlen(rlen), .wlen(wlen), .ld_uns(ld_uns), .wb_e(wb_e),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .down_syn(down_syn), .down_ack(down_ack), .wb_rd(wb_rd), .wb_data(wb_data), .wb_en(wb_en)
  );
  typedef struct {logic [4:0] rd; logic [31:0] data; logic en;} wb_t;
  wb_t q[$];
  int total = 0, bad = 0, cyc = 0, mem_lat = 1, ack_delay = 0, deliv = 0, rise_cyc = 0, done_cyc = 0;
  bit mem_seen = 0;
  logic [31:0] rdata_val = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    int cnt;
    logic [31:0] sa, sw;
    logic [2:0] sc;
    cnt = 0;
    mem_done = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_done = 0;
      mem_rdata = $urandom;
      if (mem_req) begin
        mem_seen = 1;
        if (cnt == 0) begin
          sa = mem_addr;
          sw = mem_wdata;
          sc = {mem_we, mem_len};
        end else begin
          chk("mem_stable", {mem_addr, mem_wdata}, {sa, sw});
          chk("mem_ctl_stable", {mem_we, mem_len}, sc);
        end
        cnt++;
        if (cnt >= mem_lat) begin
          mem_done = 1;
          mem_rdata = rdata_val;
          done_cyc = cyc + 1;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end
  initial begin
    bit got;
    int w;
    wb_t s, e;
    got = 0;
    w = 0;
    down_ack = 0;
    forever begin
      @(negedge clk);
      if (down_syn && !down_ack) begin
        if (!got) begin
          got = 1;
          w = 0;
          rise_cyc = cyc;
          s = '{wb_rd, wb_data, wb_en};
          chk("sb_nonempty", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_data", wb_data, e.data);
            chk("wb_en", wb_en, e.en);
          end
        end else chk("wb_stable", {wb_rd, wb_data, wb_en}, {s.rd, s.data, s.en});
        if (w >= ack_delay) down_ack = 1;
        else w++;
      end else if (down_ack && !down_syn) begin
        down_ack = 0;
        got = 0;
        deliv++;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  task automatic drive(input logic [4:0] r, input logic [31:0] a, d, input logic e_re, e_we,
                       input logic [1:0] rl, wl, input logic u, e_wb);
    rd = r; ans = a; dout = d; re = e_re; we = e_we; rlen = rl; wlen = wl; ld_uns = u; wb_e = e_wb;
    up_syn = 1;
  endtask
  task automatic wait_ack(input string tag);
    for (int i = 0; i < 50 && !up_ack; i++) @(negedge clk);
    chk(tag, up_ack, 1);
  endtask
  task automatic finish_tx(input string tag);
    int i;
    up_syn = 0;
    for (i = 0; i < 200 && !(q.size() == 0 && !down_syn && !down_ack); i++) @(negedge clk);
    chk(tag, i < 200, 1);
    @(negedge clk);
  endtask
  initial begin
    logic [1:0] lr [6] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
    logic lu [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ld [6] = '{32'hABCD8001, 32'hABCD8001, 32'h000000F0, 32'h87654321, 32'h80000000, 32'h0000007F};
    logic [31:0] lx [6] = '{32'h00008001, 32'hFFFF8001, 32'h000000F0, 32'h87654321, 32'h80000000, 32'h0000007F};
    int base, i;
    up_syn = 0; rd = 0; ans = 0; dout = 0; re = 0; we = 0; rlen = 0; wlen = 0; ld_uns = 0; wb_e = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {up_ack, down_syn, mem_req, mem_we, mem_len}, 0);
    chk("rst_mem", {mem_addr, mem_wdata}, 0);
    chk("rst_wb", {wb_rd, wb_data, wb_en}, 0);
    rst = 0;
    @(negedge clk);
    mem_seen = 0;
    q.push_back('{5'd5, 32'h1234, 1'b1});
    drive(5, 32'h1234, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("alu_ack", up_ack, 1);
    chk("alu_syn", down_syn, 1);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_rd", wb_rd, 5);
    finish_tx("alu_done");
    chk("alu_nomem", mem_seen, 0);
    mem_lat = 3;
    rdata_val = 32'h000000F0;
    q.push_back('{5'd1, 32'hFFFFFFF0, 1'b1});
    drive(1, 32'h100, 32'h55, 1, 0, 0, 2, 0, 1);
    @(negedge clk);
    chk("ldb_req", mem_req, 1);
    chk("ldb_addr", mem_addr, 32'h100);
    chk("ldb_len", mem_len, 0);
    chk("ldb_we", mem_we, 0);
    chk("ldb_nosyn", down_syn, 0);
    finish_tx("ldb_done");
    chk("ldb_lat", rise_cyc, done_cyc);
    for (int k = 0; k < 6; k++) begin
      mem_lat = k + 1;
      rdata_val = ld[k];
      q.push_back('{5'(k + 11), lx[k], 1'b1});
      drive(5'(k + 11), 32'h300 + k, 0, 1, 0, lr[k], 0, lu[k], 1);
      @(negedge clk);
      chk("ld_len", mem_len, lr[k]);
      finish_tx("ld_done");
      chk("ld_lat", rise_cyc, done_cyc);
    end
    mem_lat = 4;
    rdata_val = 32'h5A5A5A5A;
    q.push_back('{5'd3, 32'h40, 1'b0});
    drive(3, 32'h40, 32'hDEADBEEF, 0, 1, 0, 2, 0, 1);
    @(negedge clk);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_len", mem_len, 2);
    chk("st_addr", mem_addr, 32'h40);
    finish_tx("st_done");
    mem_lat = 2;
    rdata_val = 32'h1234FFFE;
    q.push_back('{5'd4, 32'h0000FFFE, 1'b1});
    drive(4, 32'h80, 32'h11111111, 1, 1, 1, 2, 1, 1);
    @(negedge clk);
    chk("rw_we", mem_we, 0);
    chk("rw_len", mem_len, 1);
    finish_tx("rw_done");
    ack_delay = 10;
    q.push_back('{5'd7, 32'hA, 1'b1});
    drive(7, 32'hA, 0, 0, 0, 0, 0, 0, 1);
    wait_ack("bp_a_ack");
    up_syn = 0;
    @(negedge clk);
    chk("bp_ack_clr", up_ack, 0);
    q.push_back('{5'd8, 32'hB, 1'b1});
    base = deliv;
    drive(8, 32'hB, 0, 0, 0, 0, 0, 0, 1);
    for (i = 0; i < 60 && !up_ack; i++) @(negedge clk);
    chk("bp_captured", up_ack, 1);
    chk("bp_order", deliv, base + 1);
    chk("bp_waited", i >= 10, 1);
    chk("bp_b_syn", {down_syn, wb_rd}, {1'b1, 5'd8});
    finish_tx("bp_done");
    ack_delay = 0;
    mem_lat = 50;
    drive(9, 32'h200, 0, 1, 0, 2, 0, 0, 1);
    @(negedge clk);
    chk("rm_req", mem_req, 1);
    up_syn = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rm_ctl", {up_ack, down_syn, mem_req, mem_we, mem_len}, 0);
    chk("rm_mem", {mem_addr, mem_wdata}, 0);
    chk("rm_wb", {wb_rd, wb_data, wb_en}, 0);
    @(negedge clk);
    rst = 0;
    mem_lat = 1;
    @(negedge clk);
    q.push_back('{5'd10, 32'hCAFE, 1'b1});
    drive(10, 32'hCAFE, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("rm_alu_syn", down_syn, 1);
    finish_tx("rm_alu_done");
    chk("sb_final", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
